cpu_bypass: RTL and testbench
=============================

// Module: cpu_bypass
// PURPOSE
// Operand forwarding and load-use hazard unit for the 5-stage CPU pipeline.
// - Sits beside the register file: p2 decode info in, p3 operands out.
// - Tracks destination registers of in-flight instructions (p3..p6).
// - Replaces stale register-file data with younger results.
// - Stalls p2 for one cycle on a load-use hazard.
// PARAMETERS
// REG_BITS   5   register index width (32 registers, $0 hardwired zero)
// WIDTH      32  datapath width
// PORTS
// clock         in   1         system clock
// reset_n       in   1         asynchronous active-low reset
// p2_valid      in   1         p2 holds a real instruction
// p2_reg_a      in   REG_BITS  operand A source register
// p2_reg_b      in   REG_BITS  operand B source register
// p2_literal_b  in   1         operand B is a literal (never forwarded)
// p2_dest_reg   in   REG_BITS  destination of p2 instruction (0 = none)
// p2_is_load    in   1         p2 instruction is a memory load
// p3_flush      in   1         branch taken in p3; p2 instruction is killed
// p3_data_a     in   WIDTH     operand A from register file (p3 timing)
// p3_data_b     in   WIDTH     operand B from register file/literal (p3 timing)
// p4_result     in   WIDTH     ALU result of instruction now in p4
// p5_result     in   WIDTH     writeback value of instruction now in p5
// p2_stall      out  1         hold p2/p1, insert bubble into p3
// p3_op_a       out  WIDTH     forwarded operand A
// p3_op_b       out  WIDTH     forwarded operand B
// BEHAVIOUR
// - Tracking regs: p3_dest, p3_load, p4_dest, p4_load, p5_dest, p6_dest, p6_result.
//   Shift each clock; p6 latches p5_dest/p5_result.
// - p3 entry gets p2_dest_reg/p2_is_load only if p2_valid & ~p2_stall & ~p3_flush.
//   Otherwise p3 gets a bubble (dest 0, load 0).
// - Reset (async, reset_n=0): all dest regs 0, load flags 0, p6_result 0, selects = REGFILE.
//   Consequences: p2_stall=0, p3_op_a=p3_data_a, p3_op_b=p3_data_b.
// - Select per operand, computed at p2 from pre-edge state and registered into p3.
//   Priority youngest first:
//   - FWD_P4: src == p3_dest
//   - FWD_P5: src == p4_dest
//   - FWD_P6: src == p5_dest
//   - REGFILE: otherwise
// - Select rules:
//   - src==0 always REGFILE.
//   - Operand B forced REGFILE when p2_literal_b.
// - FWD_P6 covers RAM read-during-write: the register file returns old data when written the same cycle as read.
// - p3 outputs are combinational muxes of the registered select: p4_result / p5_result / p6_result / p3_data_x.
// - Load-use hazard: p2_stall = p2_valid & ~p3_flush & p3_load & p3_dest!=0 &
//   (p3_dest==p2_reg_a | (~p2_literal_b & p3_dest==p2_reg_b)).
//   - Combinational output, asserted for exactly 1 cycle; the load then sits in p4, bubble in p3.
//   - Next cycle the consumer reselects.
//   - A load in p4 (p4_load) matching a source selects FWD_P5, never FWD_P4 (load data valid at p5 only).
// - Total latency: producer-to-consumer 0 bubbles for ALU, 1 bubble for load.
// - p3_flush has priority over stall; p2_stall is 0 while p3_flush=1.
// - Reset mid-operation: all in-flight tracking is discarded; no forwarding occurs on the first post-reset instruction.
// STRUCTURE
// - cpu_pkg:
//   - typedef enum logic[1:0] fwd_sel_t {REGFILE, FWD_P4, FWD_P5, FWD_P6}
//   - REG_BITS, WIDTH constants
// - Sub-module cpu_bypass_sel (combinational): src, literal flag, p3/p4/p5 dest -> fwd_sel_t.
//   Instantiated twice (A, B).
// TESTING
// 1. Back-to-back ALU dependency: r1=5 in p4 (p4_result=5), p3 reads r1, regfile stale 0 -> p3_op_a=5, p2_stall=0.
// 2. Distance 2/3: producer of r2=0x22 in p5, regfile 0 -> op=0x22.
//    Same cycle as RAM write (p6) with p6_result=0x33 -> op=0x33.
// 3. Load-use: ld r3 in p3, p2 reads r3 -> p2_stall=1 one cycle, bubble.
//    Next cycle FWD_P5 gives load data 0xDEAD.
// 4. Priority/zero: r4 in p4=1 and p5=2 -> op=1. Source $0 with $0 "written" -> op=p3_data.
//    Literal B=0x10 with p3_dest==reg_b -> op_b=0x10.
// 5. Flush: p3_flush=1 during load-use condition -> p2_stall=0, p3 bubble, no forwarding from killed instr.
// 6. Async reset asserted mid-stream -> p2_stall=0 immediately, outputs pass regfile data, tracking regs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types, widths and the operand mux used by the bypass unit.
package cpu_pkg;

    localparam int REG_BITS = 5;
    localparam int WIDTH    = 32;

    typedef enum logic [1:0] {
        REGFILE,
        FWD_P4,
        FWD_P5,
        FWD_P6
    } fwd_sel_t;

    function automatic logic [WIDTH-1:0] fwd_mux(
        input fwd_sel_t         sel,
        input logic [WIDTH-1:0] rf,
        input logic [WIDTH-1:0] p4,
        input logic [WIDTH-1:0] p5,
        input logic [WIDTH-1:0] p6
    );
        case (sel)
            FWD_P4:  return p4;
            FWD_P5:  return p5;
            FWD_P6:  return p6;
            default: return rf;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bypass_sel.sv
// Per-operand forward select: youngest in-flight producer wins.
module cpu_bypass_sel
    import cpu_pkg::*;
(
    input  logic [REG_BITS-1:0] i_src,
    input  logic                i_literal,
    input  logic [REG_BITS-1:0] i_p3_dest,
    input  logic [REG_BITS-1:0] i_p4_dest,
    input  logic [REG_BITS-1:0] i_p5_dest,
    output fwd_sel_t            o_sel
);

    always_comb begin
        o_sel = REGFILE;
        if (i_src != '0 && !i_literal) begin
            if (i_src == i_p3_dest) begin
                o_sel = FWD_P4;
            end else if (i_src == i_p4_dest) begin
                o_sel = FWD_P5;
            end else if (i_src == i_p5_dest) begin
                o_sel = FWD_P6;
            end
        end
    end

endmodule

// File: rtl/cpu_bypass.sv
// Operand forwarding and load-use stall unit for the 5-stage pipeline.
module cpu_bypass
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                p2_valid,
    input  logic [REG_BITS-1:0] p2_reg_a,
    input  logic [REG_BITS-1:0] p2_reg_b,
    input  logic                p2_literal_b,
    input  logic [REG_BITS-1:0] p2_dest_reg,
    input  logic                p2_is_load,
    input  logic                p3_flush,
    input  logic [WIDTH-1:0]    p3_data_a,
    input  logic [WIDTH-1:0]    p3_data_b,
    input  logic [WIDTH-1:0]    p4_result,
    input  logic [WIDTH-1:0]    p5_result,
    output logic                p2_stall,
    output logic [WIDTH-1:0]    p3_op_a,
    output logic [WIDTH-1:0]    p3_op_b
);

    logic [REG_BITS-1:0] r_p3_dest;
    logic [REG_BITS-1:0] r_p4_dest;
    logic [REG_BITS-1:0] r_p5_dest;
    logic [REG_BITS-1:0] r_p6_dest;
    logic                r_p3_load;
    logic                r_p4_load;
    logic [WIDTH-1:0]    r_p6_result;
    fwd_sel_t            r_sel_a;
    fwd_sel_t            r_sel_b;

    fwd_sel_t            w_sel_a;
    fwd_sel_t            w_sel_b;
    logic                w_hit_a;
    logic                w_hit_b;
    logic                w_take;

    assign w_hit_a  = (r_p3_dest == p2_reg_a);
    assign w_hit_b  = !p2_literal_b && (r_p3_dest == p2_reg_b);
    assign p2_stall = p2_valid && !p3_flush && r_p3_load
                      && (r_p3_dest != '0) && (w_hit_a || w_hit_b);
    assign w_take   = p2_valid && !p2_stall && !p3_flush;

    cpu_bypass_sel u_sel_a (
        .i_src     (p2_reg_a),
        .i_literal (1'b0),
        .i_p3_dest (r_p3_dest),
        .i_p4_dest (r_p4_dest),
        .i_p5_dest (r_p5_dest),
        .o_sel     (w_sel_a)
    );

    cpu_bypass_sel u_sel_b (
        .i_src     (p2_reg_b),
        .i_literal (p2_literal_b),
        .i_p3_dest (r_p3_dest),
        .i_p4_dest (r_p4_dest),
        .i_p5_dest (r_p5_dest),
        .o_sel     (w_sel_b)
    );

    // Stalled or killed instructions enter p3 as a bubble that forwards nothing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_p3_dest   <= '0;
            r_p4_dest   <= '0;
            r_p5_dest   <= '0;
            r_p6_dest   <= '0;
            r_p3_load   <= 1'b0;
            r_p4_load   <= 1'b0;
            r_p6_result <= '0;
            r_sel_a     <= REGFILE;
            r_sel_b     <= REGFILE;
        end else begin
            r_p3_dest   <= w_take ? p2_dest_reg : '0;
            r_p3_load   <= w_take && p2_is_load;
            r_p4_dest   <= r_p3_dest;
            r_p4_load   <= r_p3_load;
            r_p5_dest   <= r_p4_dest;
            r_p6_dest   <= r_p5_dest;
            r_p6_result <= p5_result;
            r_sel_a     <= w_take ? w_sel_a : REGFILE;
            r_sel_b     <= w_take ? w_sel_b : REGFILE;
        end
    end

    assign p3_op_a = fwd_mux(r_sel_a, p3_data_a, p4_result,
                             p5_result, r_p6_result);
    assign p3_op_b = fwd_mux(r_sel_b, p3_data_b, p4_result,
                             p5_result, r_p6_result);

    // A load in p4 has no data yet; the stall guarantees it is never forwarded.
    a_no_p4_load_a: assert property (@(posedge clock) disable iff (!reset_n)
        (r_sel_a == FWD_P4) |-> !r_p4_load);
    a_no_p4_load_b: assert property (@(posedge clock) disable iff (!reset_n)
        (r_sel_b == FWD_P4) |-> !r_p4_load);
    a_p6_real_a: assert property (@(posedge clock) disable iff (!reset_n)
        (r_sel_a == FWD_P6) |-> (r_p6_dest != '0));
    a_p6_real_b: assert property (@(posedge clock) disable iff (!reset_n)
        (r_sel_b == FWD_P6) |-> (r_p6_dest != '0));

endmodule

// File: tb/tb_cpu_bypass.sv
// Scenario bench for cpu_bypass: expected operands queued at issue, compared in p3.
module tb_cpu_bypass;
    import cpu_pkg::*;

    logic                clock;
    logic                reset_n;
    logic                p2_valid;
    logic [REG_BITS-1:0] p2_reg_a;
    logic [REG_BITS-1:0] p2_reg_b;
    logic                p2_literal_b;
    logic [REG_BITS-1:0] p2_dest_reg;
    logic                p2_is_load;
    logic                p3_flush;
    logic [WIDTH-1:0]    p3_data_a;
    logic [WIDTH-1:0]    p3_data_b;
    logic [WIDTH-1:0]    p4_result;
    logic [WIDTH-1:0]    p5_result;
    logic                p2_stall;
    logic [WIDTH-1:0]    p3_op_a;
    logic [WIDTH-1:0]    p3_op_b;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    cpu_bypass dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .p2_valid     (p2_valid),
        .p2_reg_a     (p2_reg_a),
        .p2_reg_b     (p2_reg_b),
        .p2_literal_b (p2_literal_b),
        .p2_dest_reg  (p2_dest_reg),
        .p2_is_load   (p2_is_load),
        .p3_flush     (p3_flush),
        .p3_data_a    (p3_data_a),
        .p3_data_b    (p3_data_b),
        .p4_result    (p4_result),
        .p5_result    (p5_result),
        .p2_stall     (p2_stall),
        .p3_op_a      (p3_op_a),
        .p3_op_b      (p3_op_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic p2_set(input logic v, input logic [REG_BITS-1:0] a,
                          input logic [REG_BITS-1:0] b, input logic lit,
                          input logic [REG_BITS-1:0] d, input logic ld);
        p2_valid     = v;
        p2_reg_a     = a;
        p2_reg_b     = b;
        p2_literal_b = lit;
        p2_dest_reg  = d;
        p2_is_load   = ld;
        p3_flush     = 1'b0;
    endtask

    task automatic p3_set(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                          input logic [WIDTH-1:0] r4, input logic [WIDTH-1:0] r5);
        p3_data_a = da;
        p3_data_b = db;
        p4_result = r4;
        p5_result = r5;
    endtask

    task automatic drain();
        p2_set(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (4) tick();
    endtask

    task automatic pop_compare();
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            n_total++;
            if (p3_op_a !== e.a)
                $display("FAIL %s op_a: got %h want %h", e.tag, p3_op_a, e.a);
            else n_pass++;
            n_total++;
            if (p3_op_b !== e.b)
                $display("FAIL %s op_b: got %h want %h", e.tag, p3_op_b, e.b);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        p2_set(1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 1'b1);
        p3_set(32'h1111_2222, 32'h3333_4444, 32'h5, 32'h6);
        sb.push_back('{"reset", 32'h1111_2222, 32'h3333_4444});
        repeat (2) @(posedge clock);
        #2;
        n_total++;
        if (p2_stall !== 1'b0)
            $display("FAIL reset_stall: got %b want 0", p2_stall);
        else n_pass++;
        pop_compare();
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b0);
        tick();
        p2_set(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{"b2b", 32'h5, 32'h77});
        #1;
        n_total++;
        if (p2_stall !== 1'b0)
            $display("FAIL b2b_stall: got %b want 0", p2_stall);
        else n_pass++;
        tick();
        p3_set(32'h0, 32'h77, 32'h5, 32'hAA);
        #1;
        pop_compare();
    endtask

    task automatic test_distance();
        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0);
        tick();
        p2_set(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{"dist2", 32'h22, 32'h5B});
        tick();
        p3_set(32'h0, 32'h5B, 32'h11, 32'h22);
        #1;
        pop_compare();

        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd2, 1'b0, 5'd0, 1'b0);
        p3_set(32'h0, 32'h0, 32'h0, 32'h33);
        sb.push_back('{"dist3", 32'hA0, 32'h33});
        tick();
        p3_set(32'hA0, 32'h0, 32'h44, 32'h55);
        #1;
        pop_compare();
    endtask

    task automatic test_load_use();
        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        p2_set(1'b1, 5'd3, 5'd0, 1'b0, 5'd9, 1'b0);
        #1;
        n_total++;
        if (p2_stall !== 1'b1)
            $display("FAIL lu_stall: got %b want 1", p2_stall);
        else n_pass++;
        tick();
        p3_set(32'h1234, 32'h0, 32'hBEEF, 32'h0);
        sb.push_back('{"lu_bubble", 32'h1234, 32'h0});
        #1;
        n_total++;
        if (p2_stall !== 1'b0)
            $display("FAIL lu_release: got %b want 0", p2_stall);
        else n_pass++;
        pop_compare();
        sb.push_back('{"lu_fwd", 32'hDEAD, 32'h0});
        tick();
        p3_set(32'h0, 32'h0, 32'h0BAD, 32'hDEAD);
        #1;
        pop_compare();
    endtask

    task automatic test_priority_zero();
        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b0);
        tick();
        p2_set(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{"prio", 32'h1, 32'h3C});
        tick();
        p3_set(32'h0, 32'h3C, 32'h1, 32'h2);
        #1;
        pop_compare();

        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{"zero", 32'hA, 32'hB});
        tick();
        p3_set(32'hA, 32'hB, 32'hEE, 32'hFF);
        #1;
        pop_compare();

        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b0);
        tick();
        p2_set(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 1'b0);
        sb.push_back('{"literal", 32'h1, 32'h10});
        tick();
        p3_set(32'h1, 32'h10, 32'h66, 32'h77);
        #1;
        pop_compare();

        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        p2_set(1'b1, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        n_total++;
        if (p2_stall !== 1'b0)
            $display("FAIL lit_no_stall: got %b want 0", p2_stall);
        else n_pass++;
    endtask

    task automatic test_flush();
        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        p2_set(1'b1, 5'd3, 5'd0, 1'b0, 5'd5, 1'b0);
        p3_flush = 1'b1;
        #1;
        n_total++;
        if (p2_stall !== 1'b0)
            $display("FAIL flush_stall: got %b want 0", p2_stall);
        else n_pass++;
        tick();
        p2_set(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{"flush_kill", 32'h55, 32'h0});
        tick();
        p3_set(32'h55, 32'h0, 32'hBAD, 32'hCAFE);
        #1;
        pop_compare();
    endtask

    task automatic test_reset_mid();
        drain();
        p2_set(1'b1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b0);
        tick();
        p2_set(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1);
        tick();
        p2_set(1'b1, 5'd2, 5'd1, 1'b0, 5'd0, 1'b0);
        #1;
        n_total++;
        if (p2_stall !== 1'b1)
            $display("FAIL rst_pre_stall: got %b want 1", p2_stall);
        else n_pass++;
        #1;
        reset_n = 1'b0;
        p3_set(32'h71, 32'h72, 32'h73, 32'h74);
        sb.push_back('{"rst_async", 32'h71, 32'h72});
        #1;
        n_total++;
        if (p2_stall !== 1'b0)
            $display("FAIL rst_stall: got %b want 0", p2_stall);
        else n_pass++;
        pop_compare();
        tick();
        #1;
        reset_n = 1'b1;
        sb.push_back('{"rst_first", 32'h81, 32'h82});
        tick();
        p3_set(32'h81, 32'h82, 32'h83, 32'h84);
        #1;
        pop_compare();
    endtask

    initial begin
        reset_n = 1'b0;
        p2_set(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        p3_set(32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_priority_zero();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
